// File: rtl/udl_count_mod_if.sv
// Control and status bundle for udl_count_mod: count/load controls in,
// registered count and bound flags out.
interface udl_count_mod_if #(
   parameter int unsigned WIDTH = 10
);
   logic             en;
   logic             up;
   logic             down;
   logic             load;
   logic [WIDTH-1:0] in;
   logic             sat;
   logic [WIDTH-1:0] out;
   logic             at_max;
   logic             at_min;
   logic             wrap;

   modport master (
      output en, up, down, load, in, sat,
      input  out, at_max, at_min, wrap
   );

   modport slave (
      input  en, up, down, load, in, sat,
      output out, at_max, at_min, wrap
   );
endinterface

// File: rtl/udl_count_mod.sv
// Up/down modulo-(MAX+1) counter with clamped parallel load and wrap pulse.
// Define UDL_COUNT_SAT_EN to honour the sat input; otherwise it always wraps.
module udl_count_mod #(
   parameter int unsigned      WIDTH   = 10,
   parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic            clk,
   input logic            rst,
   udl_count_mod_if.slave bus
);

   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             sat_eff;

`ifdef UDL_COUNT_SAT_EN
   assign sat_eff = bus.sat;
`else
   assign sat_eff = 1'b0;
`endif

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         out_d = (bus.in > MAX) ? MAX : bus.in;
      end else if (bus.en) begin
         if (bus.up && !bus.down) begin
            if (out_q != MAX) begin
               out_d = out_q + WIDTH'(1);
            end else if (!sat_eff) begin
               out_d  = '0;
               wrap_d = 1'b1;
            end
         end else if (bus.down && !bus.up) begin
            if (out_q != '0) begin
               out_d = out_q - WIDTH'(1);
            end else if (!sat_eff) begin
               out_d  = MAX;
               wrap_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= RST_VAL;
         wrap_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.out    = out_q;
   assign bus.wrap   = wrap_q;
   assign bus.at_max = (out_q == MAX);
   assign bus.at_min = (out_q == '0);

endmodule

// File: tb/tb_udl_count_mod.sv
// Self-checking bench for udl_count_mod (WIDTH=10, MAX=999, RST_VAL=0).
module tb_udl_count_mod;

   localparam int unsigned W   = 10;
   localparam logic [W-1:0] MX = 10'd999;

   logic clk = 1'b0;
   logic rst;

   udl_count_mod_if #(.WIDTH(W)) bus ();

   udl_count_mod #(.WIDTH(W), .MAX(MX), .RST_VAL(10'd0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         rst, load, en, up, down, sat;
      logic [W-1:0] in;
      logic [W-1:0] eo;
      logic         ew;
   } vec_t;

   typedef struct {
      string        name;
      logic [W-1:0] eo;
      logic         ew;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void add(string n, logic r, logic ld, logic e, logic u,
                               logic d, logic s, int i, int eo, logic ew);
      vec_t v;
      v.name = n; v.rst = r; v.load = ld; v.en = e; v.up = u; v.down = d;
      v.sat = s; v.in = W'(i); v.eo = W'(eo); v.ew = ew;
      vecs.push_back(v);
   endfunction

   // Drive one edge's inputs, queue the expectation, then check after the edge.
   task automatic apply(input vec_t v);
      exp_t e;
      rst = v.rst; bus.load = v.load; bus.en = v.en; bus.up = v.up;
      bus.down = v.down; bus.sat = v.sat; bus.in = v.in;
      e.name = v.name; e.eo = v.eo; e.ew = v.ew;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.out !== e.eo || bus.wrap !== e.ew ||
          bus.at_max !== (e.eo == MX) || bus.at_min !== (e.eo == '0)) begin
         bad++;
         $display("FAIL %s: got out=%0d wrap=%b at_max=%b at_min=%b, want out=%0d wrap=%b at_max=%b at_min=%b",
                  e.name, bus.out, bus.wrap, bus.at_max, bus.at_min,
                  e.eo, e.ew, (e.eo == MX), (e.eo == '0));
      end
   endtask

   logic [W-1:0] m_out;
   logic         m_wrap;
   logic         m_sat;
   vec_t         rv;

   initial begin
      rst = 1'b0; bus.load = 0; bus.en = 0; bus.up = 0; bus.down = 0;
      bus.sat = 0; bus.in = '0;
      @(posedge clk); #1;

      for (int k = 0; k < 3; k++) add("reset_hold", 1, 1, 1, 1, 0, 0, 500, 0, 0);
      add("load_998",   0, 1, 0, 0, 0, 0, 998, 998, 0);
      add("up_to_max",  0, 0, 1, 1, 0, 0, 0,   999, 0);
      add("up_wrap",    0, 0, 1, 1, 0, 0, 0,   0,   1);
      add("up_after",   0, 0, 1, 1, 0, 0, 0,   1,   0);
      add("load_clamp", 0, 1, 0, 0, 0, 0, 1023, 999, 0);
      for (int k = 0; k < 5; k++) add("en0_hold", 0, 0, 0, 1, 0, 0, 0, 999, 0);
      add("load_400",   0, 1, 0, 0, 0, 0, 400, 400, 0);
      add("updown_hold",0, 0, 1, 1, 1, 0, 0,   400, 0);
      add("load_prio",  0, 1, 1, 1, 1, 0, 7,   7,   0);
      add("load_10",    0, 1, 0, 0, 0, 0, 10,  10,  0);
      add("cnt_11",     0, 0, 1, 1, 0, 0, 0,   11,  0);
      add("cnt_12",     0, 0, 1, 1, 0, 0, 0,   12,  0);
      add("cnt_13",     0, 0, 1, 1, 0, 0, 0,   13,  0);
      add("mid_rst",    1, 0, 1, 1, 0, 0, 0,   0,   0);
      add("resume_1",   0, 0, 1, 1, 0, 0, 0,   1,   0);
      add("resume_2",   0, 0, 1, 1, 0, 0, 0,   2,   0);
      add("load_0",     0, 1, 0, 0, 0, 0, 0,   0,   0);
      add("down_wrap",  0, 0, 1, 0, 1, 0, 0,   999, 1);
      add("down_998",   0, 0, 1, 0, 1, 0, 0,   998, 0);
      add("load_1",     0, 1, 0, 0, 0, 1, 1,   1,   0);
      add("sat_down_0", 0, 0, 1, 0, 1, 1, 0,   0,   0);
`ifdef UDL_COUNT_SAT_EN
      add("sat_lo_a",   0, 0, 1, 0, 1, 1, 0,   0,   0);
      add("sat_lo_b",   0, 0, 1, 0, 1, 1, 0,   0,   0);
      add("load_999",   0, 1, 0, 0, 0, 1, 999, 999, 0);
      add("sat_hi",     0, 0, 1, 1, 0, 1, 0,   999, 0);
      add("sat_off_hi", 0, 0, 1, 1, 0, 0, 0,   0,   1);
`else
      add("nosat_lo_a", 0, 0, 1, 0, 1, 1, 0,   999, 1);
      add("nosat_lo_b", 0, 0, 1, 0, 1, 1, 0,   998, 0);
      add("load_999",   0, 1, 0, 0, 0, 1, 999, 999, 0);
      add("nosat_hi",   0, 0, 1, 1, 0, 1, 0,   0,   1);
      add("nosat_hi2",  0, 0, 1, 1, 0, 1, 0,   1,   0);
`endif
      foreach (vecs[i]) apply(vecs[i]);

      // Random traffic against an independent behavioural model.
      m_out = vecs[vecs.size()-1].eo;
      for (int k = 0; k < 400; k++) begin
         rv.name = "random";
         rv.rst  = ($urandom_range(0, 49) == 0);
         rv.load = ($urandom_range(0, 9) == 0);
         rv.en   = ($urandom_range(0, 3) != 0);
         rv.up   = $urandom_range(0, 1);
         rv.down = $urandom_range(0, 1);
         rv.sat  = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       rv.in = W'($urandom_range(995, 1023));
            1:       rv.in = W'($urandom_range(0, 3));
            default: rv.in = W'($urandom_range(0, 1023));
         endcase
`ifdef UDL_COUNT_SAT_EN
         m_sat = rv.sat;
`else
         m_sat = 1'b0;
`endif
         m_wrap = 1'b0;
         if (rv.rst) m_out = '0;
         else if (rv.load) m_out = (rv.in > MX) ? MX : rv.in;
         else if (rv.en && rv.up && rv.down) m_out = m_out;
         else if (rv.en && rv.up) begin
            if (m_out < MX) m_out = m_out + 1'b1;
            else if (!m_sat) begin m_out = '0; m_wrap = 1'b1; end
         end else if (rv.en && rv.down) begin
            if (m_out > 0) m_out = m_out - 1'b1;
            else if (!m_sat) begin m_out = MX; m_wrap = 1'b1; end
         end
         rv.eo = m_out;
         rv.ew = m_wrap;
         apply(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
